sprite_pos_sched: RTL

- Frame-synchronous scheduler for sprite coordinates feeding the bit generator's sprite pipelines (monkey, platform 1, platform 2).
- Game/ALU side writes new positions into shadow registers through a req/ack handshake at any time.
- The block commits dirty shadow entries into the live coordinate outputs only at a frame-start pulse (start of vertical blanking). This prevents tearing and mid-frame position changes.

---
 rtl/sprite_pos_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sprite_pos_sched.sv
// sprite_pos_sched: frame-synchronous commit of sprite coordinates.
// The game side writes positions into shadow registers through a req/ack
// handshake. Dirty shadow entries are copied to the live outputs one sprite
// per cycle, starting at the frame_start pulse, so a sprite never moves
// mid-frame.
// Optional build macro SPR_POS_CLAMP_EN: when defined, written coordinates are
// clamped to [0, H_LIM-1] / [0, V_LIM-1] before they are stored.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepting writes into the shadow; waiting for frame_start
// COMMIT | copying shadow -> live for index cidx; writes are stalled
module sprite_pos_sched #(
  parameter int CORDW = 16,
  parameter int NSPR  = 3,
  parameter int IDXW  = 2,
  parameter int H_LIM = 640,
  parameter int V_LIM = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    wr_req,
  input  logic [IDXW-1:0]         wr_idx,
  input  logic [CORDW-1:0]        wr_x,
  input  logic [CORDW-1:0]        wr_y,
  output logic                    wr_ack,
  output logic                    wr_err,
  output logic [NSPR*CORDW-1:0]   spr_x,
  output logic [NSPR*CORDW-1:0]   spr_y,
  output logic                    pending,
  output logic                    commit_done,
  output logic                    overrun
);

  // A bad parameter set is caught at elaboration rather than in silicon.
  if (((1 << IDXW) < NSPR) || (NSPR < 1) || (H_LIM < 1) || (V_LIM < 1)) begin : g_bad_param
    $error("sprite_pos_sched: invalid parameters");
  end

  typedef enum logic {IDLE, COMMIT} state_t;

  localparam logic [IDXW:0]   NSPR_W = (IDXW+1)'(NSPR);
  localparam logic [IDXW-1:0] LAST   = IDXW'(NSPR - 1);
  localparam logic [IDXW-1:0] PRE    = IDXW'((NSPR > 1) ? (NSPR - 2) : 0);

  state_t          state;
  logic [IDXW-1:0] cidx;
  logic [CORDW-1:0] sh_x [NSPR];
  logic [CORDW-1:0] sh_y [NSPR];
  logic [NSPR-1:0] dirty;
  logic            idx_ok;
  logic [CORDW-1:0] in_x;
  logic [CORDW-1:0] in_y;

  assign idx_ok  = ({1'b0, wr_idx} < NSPR_W);
  assign pending = |dirty;

`ifdef SPR_POS_CLAMP_EN
  // Signed clamp into [0, lim-1]; negative values pin to 0.
  function automatic logic [CORDW-1:0] clamp(input logic [CORDW-1:0] v, input int lim);
    if ($signed(v) < 0) return '0;
    if ($signed(v) >= lim) return CORDW'(lim - 1);
    return v;
  endfunction

  assign in_x = clamp(wr_x, H_LIM);
  assign in_y = clamp(wr_y, V_LIM);
`else
  assign in_x = wr_x;
  assign in_y = wr_y;
`endif

  // FSM, write handshake, shadow storage and commit to live outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cidx        <= '0;
      dirty       <= '0;
      spr_x       <= '0;
      spr_y       <= '0;
      wr_ack      <= 1'b0;
      wr_err      <= 1'b0;
      commit_done <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NSPR; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
      end
    end else begin
      wr_ack      <= 1'b0;
      wr_err      <= 1'b0;
      commit_done <= 1'b0;
      overrun     <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            // frame_start wins over a write sampled in the same cycle
            state       <= COMMIT;
            cidx        <= '0;
            commit_done <= (NSPR == 1);
          end else if (wr_req && !wr_ack) begin
            // !wr_ack: the request still high during its ack cycle is the
            // same transaction and must not be taken twice
            wr_ack <= 1'b1;
            wr_err <= !idx_ok;
            for (int i = 0; i < NSPR; i++) begin
              if (idx_ok && (wr_idx == IDXW'(i))) begin
                sh_x[i]  <= in_x;
                sh_y[i]  <= in_y;
                dirty[i] <= 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          overrun <= frame_start;
          for (int i = 0; i < NSPR; i++) begin
            if ((cidx == IDXW'(i)) && dirty[i]) begin
              spr_x[i*CORDW +: CORDW] <= sh_x[i];
              spr_y[i*CORDW +: CORDW] <= sh_y[i];
              dirty[i]                <= 1'b0;
            end
          end
          if (cidx == LAST) begin
            state <= IDLE;
            cidx  <= '0;
          end else begin
            cidx        <= cidx + 1'b1;
            commit_done <= (cidx == PRE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
